// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO byte serializer.
package fifo_ser_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    // A byte count of zero, or one larger than the word, means "whole word".
    function automatic int unsigned ser_clamp_nbytes(input int unsigned nbytes,
                                                     input int unsigned word_bytes);
        return ((nbytes == 0) || (nbytes > word_bytes)) ? word_bytes : nbytes;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Serializes multi-byte stream words into single-byte FIFO writes, stalling on fifo_full.
// Optional macro SER_MSB_FIRST_EN: emit the most-significant byte first (default LSB first).
module fifo_byte_serializer
    import fifo_ser_pkg::*;
#(
    parameter  int unsigned WORD_BYTES = 4,
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES) + 1
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WORD_BYTES*8-1:0]    s_data,
    input  logic [CNT_W-1:0]           s_nbytes,
    output logic                       fifo_wr,
    output logic [7:0]                 fifo_data,
    input  logic                       fifo_full,
    output logic                       busy
);

    localparam int unsigned HOLD_W = WORD_BYTES * BYTE_W;

    if ((WORD_BYTES < 2) || (WORD_BYTES > 8)) begin : g_bad_width
        $error("fifo_byte_serializer: WORD_BYTES must be in 2..8");
    end

    ser_state_t         state_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_shifted;
    logic [CNT_W-1:0]   rem_q;
    logic [CNT_W-1:0]   nbytes_clamped;
    logic               last_byte;

    assign nbytes_clamped = CNT_W'(ser_clamp_nbytes(32'(s_nbytes), WORD_BYTES));
    assign last_byte      = (rem_q == CNT_W'(1));
    assign busy           = (state_q == SER_SHIFT);
    assign fifo_wr        = (state_q == SER_SHIFT) && !fifo_full;

    // Ready on the last byte lets the next word load with no idle cycle.
    assign s_ready = !rst && ((state_q == SER_IDLE) ||
                              ((state_q == SER_SHIFT) && last_byte && !fifo_full));

`ifdef SER_MSB_FIRST_EN
    assign hold_shifted = hold_q << BYTE_W;
    assign fifo_data    = hold_q[HOLD_W-1 -: BYTE_W];
`else
    assign hold_shifted = hold_q >> BYTE_W;
    assign fifo_data    = hold_q[BYTE_W-1:0];
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= SER_IDLE;
            hold_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                SER_IDLE: begin
                    if (s_valid) begin
                        hold_q  <= s_data;
                        rem_q   <= nbytes_clamped;
                        state_q <= SER_SHIFT;
                    end
                end
                SER_SHIFT: begin
                    if (fifo_wr) begin
                        if (last_byte && s_valid) begin
                            hold_q <= s_data;
                            rem_q  <= nbytes_clamped;
                        end else begin
                            hold_q <= hold_shifted;
                            rem_q  <= rem_q - CNT_W'(1);
                            if (last_byte) begin
                                state_q <= SER_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= SER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench for fifo_byte_serializer with a behavioural 16-deep byte FIFO on the write side.
module tb_fifo_byte_serializer;

    localparam int unsigned WB    = 4;
    localparam int unsigned CW    = $clog2(WB) + 1;
    localparam int unsigned DEPTH = 16;

    logic              clock = 1'b0;
    logic              rst   = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [WB*8-1:0]   s_data = '0;
    logic [CW-1:0]     s_nbytes = '0;
    logic              fifo_wr;
    logic [7:0]        fifo_data;
    logic              fifo_full = 1'b0;
    logic              busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] sb[$];
    logic [7:0] fifo_q[$];
    logic       wr_seen = 1'b0;
    logic [7:0] wr_byte = '0;
    int         pop_n   = 0;
    int         run     = 0;
    int         max_run = 0;

    fifo_byte_serializer #(.WORD_BYTES(WB)) dut (
        .clock     (clock),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_nbytes  (s_nbytes),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [WB*8-1:0] data, input int unsigned i);
        logic [WB*8-1:0] d;
        d = data;
`ifdef SER_MSB_FIRST_EN
        return d[(WB-1-i)*8 +: 8];
`else
        return d[i*8 +: 8];
`endif
    endfunction

    function automatic int unsigned clamp_n(input int unsigned nb);
        return (nb == 0 || nb > WB) ? WB : nb;
    endfunction

    // Monitor: every write is checked against the scoreboard head.
    always @(negedge clock) begin
        wr_seen = fifo_wr;
        wr_byte = fifo_data;
        if (fifo_wr) begin
            run++;
            if (run > max_run) max_run = run;
            check("wr_not_full", 64'(fifo_full), 64'(0));
            if (sb.size() == 0) check("unexpected_wr", 64'(1), 64'(0));
            else check("byte", 64'(fifo_data), 64'(sb.pop_front()));
        end else begin
            run = 0;
        end
    end

    // Behavioural FIFO: commits the write seen before the edge, then applies pops.
    always @(posedge clock) begin
        #1;
        if (wr_seen && fifo_q.size() < DEPTH) fifo_q.push_back(wr_byte);
        while (pop_n > 0 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_n--;
        end
        pop_n = 0;
        fifo_full = (fifo_q.size() >= DEPTH);
    end

    // Leaves s_valid high after the accept edge; caller decides what follows.
    task automatic send_word(input logic [WB*8-1:0] data, input logic [CW-1:0] nb);
        bit accepted = 0;
        s_valid  = 1'b1;
        s_data   = data;
        s_nbytes = nb;
        for (int c = 0; c < 64 && !accepted; c++) begin
            @(negedge clock);
            if (s_ready) begin
                accepted = 1;
                for (int unsigned i = 0; i < clamp_n(int'(nb)); i++) sb.push_back(exp_byte(data, i));
            end
            @(posedge clock);
            #1;
        end
        if (!accepted) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) break;
        end
        check("drain_sb", 64'(sb.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));
    endtask

    task automatic flush_fifo();
        @(negedge clock);
        pop_n = fifo_q.size();
        repeat (2) @(posedge clock);
        #2;
    endtask

    initial begin
        logic [WB*8-1:0] w;
        bit found;

        // Reset state
        #12;
        check("rst_wr", 64'(fifo_wr), 64'(0));
        check("rst_data", 64'(fifo_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(s_ready), 64'(0));
        @(posedge clock); #1;
        rst = 1'b0;
        @(negedge clock);
        check("idle_ready", 64'(s_ready), 64'(1));
        @(posedge clock); #1;

        // 1: single full word, ready only on last byte
        send_word(32'h44332211, 3'd4);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t1_wr", 64'(fifo_wr), 64'(1));
            check("t1_ready", 64'(s_ready), 64'(i == 3));
        end
        @(posedge clock); #1;
        @(negedge clock);
        check("t1_busy_after", 64'(busy), 64'(0));
        wait_drain();
        flush_fifo();

        // 2: back-to-back words, no bubble
        run = 0; max_run = 0;
        send_word(32'hA3A2A1A0, 3'd4);
        send_word(32'hB3B2B1B0, 3'd4);
        s_valid = 1'b0;
        wait_drain();
        check("t2_max_run", 64'(max_run), 64'(8));
        check("t2_fifo_cnt", 64'(fifo_q.size()), 64'(8));
        flush_fifo();

        // 3: stall on full, resume after pops
        @(negedge clock);
        for (int i = 0; i < 14; i++) fifo_q.push_back(8'h50 + 8'(i));
        @(posedge clock); #2;
        w = 32'hDDCCBBAA;
        send_word(w, 3'd4);
        s_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("t3_full", 64'(fifo_full), 64'(1));
        check("t3_stall_wr", 64'(fifo_wr), 64'(0));
        check("t3_stall_busy", 64'(busy), 64'(1));
        check("t3_stall_ready", 64'(s_ready), 64'(0));
        check("t3_pending", 64'(sb.size()), 64'(2));
        pop_n = 2;
        wait_drain();
        check("t3_fifo_cnt", 64'(fifo_q.size()), 64'(16));
        for (int unsigned i = 0; i < 4; i++)
            check("t3_contents", 64'(fifo_q[12+i]), 64'(exp_byte(w, i)));
        flush_fifo();

        // 4: one-byte word then zero count (whole word)
        send_word(32'h000000EE, 3'd1);
        send_word(32'h87654321, 3'd0);
        s_valid = 1'b0;
        wait_drain();
        flush_fifo();

        // 5: reset mid-word discards the remainder
        send_word(32'h0F0E0D0C, 3'd4);
        s_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(posedge clock); #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("t5_rst_wr", 64'(fifo_wr), 64'(0));
        check("t5_rst_ready", 64'(s_ready), 64'(0));
        check("t5_rst_busy", 64'(busy), 64'(0));
        @(posedge clock); #1;
        rst = 1'b0;
        repeat (8) @(negedge clock);
        check("t5_busy_after", 64'(busy), 64'(0));
        check("t5_fifo_cnt", 64'(fifo_q.size()), 64'(2));
        found = 0;
        foreach (fifo_q[i]) if (fifo_q[i] == 8'h0E || fifo_q[i] == 8'h0F) found = 1;
        check("t5_no_tail", 64'(found), 64'(0));
        flush_fifo();

        // 6: short word picks the low (or, MSB-first, the high) bytes
        send_word(32'h44332211, 3'd4);
        send_word(32'h44332211, 3'd2);
        s_valid = 1'b0;
        wait_drain();
        check("t6_fifo_cnt", 64'(fifo_q.size()), 64'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
